vscale_mem_arbiter: RTL

Shares one unified memory port between the core's instruction-fetch (imem) and data (dmem) interfaces. The port uses a valid/ready request channel and returns responses in order. The block sits between the vscale pipeline and the memory model, in place of separate imem/dmem arrays. Data requests win by default. A starvation counter guarantees forward progress for fetch. An in-order owner-tag FIFO routes each response back to the requester that issued it.

---
 rtl/vscale_mem_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vscale_mem_arbiter.sv
// Shares one memory port between fetch and data; data wins unless fetch has starved, responses routed in order.
// Latency: request and response paths are combinational; backpressure: ready drops while memory stalls or the tag FIFO is full.

module vscale_mem_arbiter_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]     store [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic                 do_push;
    logic                 do_pop;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_WIDTH'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = store[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end
endmodule

module vscale_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    imem_req_valid,
    output logic                    imem_req_ready,
    input  logic [ADDR_WIDTH-1:0]   imem_addr,
    output logic                    imem_resp_valid,
    output logic [DATA_WIDTH-1:0]   imem_resp_data,
    input  logic                    dmem_req_valid,
    output logic                    dmem_req_ready,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr,
    input  logic                    dmem_wen,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata,
    input  logic [DATA_WIDTH/8-1:0] dmem_wmask,
    output logic                    dmem_resp_valid,
    output logic [DATA_WIDTH-1:0]   dmem_resp_data,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data,
    output logic                    protocol_err
);
    localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);

    logic [CNT_WIDTH-1:0] starve_cnt;
    logic                 force_imem;
    logic                 sel_imem;
    logic                 sel_dmem;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 head_dmem;
    logic                 accept;
    logic                 pop;

    assign force_imem = imem_req_valid && (starve_cnt == CNT_WIDTH'(STARVE_LIMIT));
    assign sel_dmem   = dmem_req_valid && !force_imem;
    assign sel_imem   = imem_req_valid && !sel_dmem;

    // A full tag FIFO blocks issue even when a response frees a slot this cycle.
    assign mem_req_valid  = (imem_req_valid || dmem_req_valid) && !fifo_full;
    assign imem_req_ready = sel_imem && mem_req_ready && !fifo_full;
    assign dmem_req_ready = sel_dmem && mem_req_ready && !fifo_full;
    assign accept         = mem_req_valid && mem_req_ready;

    assign mem_addr  = sel_dmem ? dmem_addr : imem_addr;
    assign mem_wen   = sel_dmem && dmem_wen;
    assign mem_wdata = sel_dmem ? dmem_wdata : '0;
    assign mem_wmask = sel_dmem ? dmem_wmask : '0;

    assign pop             = mem_resp_valid && !fifo_empty;
    assign imem_resp_valid = pop && !head_dmem;
    assign dmem_resp_valid = pop && head_dmem;
    assign imem_resp_data  = mem_resp_data;
    assign dmem_resp_data  = mem_resp_data;

    vscale_mem_arbiter_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (sel_dmem),
        .pop       (pop),
        .pop_data  (head_dmem),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Counts data grants that overtook a waiting fetch; saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!imem_req_valid) begin
            starve_cnt <= '0;
        end else if (accept && sel_imem) begin
            starve_cnt <= '0;
        end else if (accept && sel_dmem && (starve_cnt < CNT_WIDTH'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            protocol_err <= 1'b0;
        end else if (mem_resp_valid && fifo_empty) begin
            protocol_err <= 1'b1;
        end
    end
endmodule
